// File: rtl/eth_pkg.sv
// Shared types, constants and CRC helpers for the Ethernet transmit framer.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // MSB-first CRC-32 register. Data bit 0 is shifted in first, which matches
  // the LSB-first order in which the byte leaves on the wire.
  function automatic logic [31:0] crc32_byte_next(input logic [31:0] crc,
                                                  input logic [7:0]  data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_tx_crc_unit.sv
// CRC-32 accumulator; init wins over enable so a new frame restarts cleanly.
module eth_tx_crc_unit
  import eth_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;

  // CRC register: reset/init to all ones, fold in one byte per enable.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)    crc_q <= CRC_INIT;
    else if (init_i) crc_q <= CRC_INIT;
    else if (en_i)   crc_q <= crc32_byte_next(crc_q, data_i);
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet MAC transmit framer: preamble/SFD, payload, zero pad, FCS, IFG.
// Every state step happens only on a Tx_ready byte-time strobe.
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int MIN_FRAME      = 60,
  parameter int PREAMBLE_BYTES = 7,
  parameter int IFG_BYTES      = 12
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] In_data,
  input  logic       In_valid,
  input  logic       In_last,
  output logic       In_ready,
  input  logic       Tx_ready,
  output logic [7:0] Tx_data,
  output logic       Tx_en,
  output logic       Tx_err,
  output logic       Frame_done,
  output logic       Busy
);

  localparam logic [15:0] MIN_CNT  = 16'(MIN_FRAME);
  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_BYTES - 1);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]  aux_q, aux_d;          // preamble / FCS byte / IFG position
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_err_q, tx_err_d;
  logic        done_q, done_d;
  logic        crc_init, crc_en;
  logic [7:0]  crc_din, fcs_src;
  logic [31:0] crc;

  eth_tx_crc_unit u_crc (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .init_i (crc_init),
    .en_i   (crc_en),
    .data_i (crc_din),
    .crc_o  (crc)
  );

  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // FCS byte source: most significant CRC byte goes out first.
  always_comb begin
    fcs_src = crc[31:24];
    case (aux_q[1:0])
      2'd1:    fcs_src = crc[23:16];
      2'd2:    fcs_src = crc[15:8];
      2'd3:    fcs_src = crc[7:0];
      default: fcs_src = crc[31:24];
    endcase
  end

  // Next state and output bytes; everything holds unless Tx_ready strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    aux_d     = aux_q;
    tx_data_d = tx_data_q;
    tx_en_d   = tx_en_q;
    tx_err_d  = tx_err_q;
    done_d    = 1'b0;
    crc_init  = 1'b0;
    crc_en    = 1'b0;
    crc_din   = In_data;
    if (Tx_ready) begin
      case (state_q)
        ST_IDLE: begin
          tx_data_d = 8'h00;
          tx_en_d   = 1'b0;
          tx_err_d  = 1'b0;
          if (In_valid) begin
            tx_data_d = PREAMBLE_BYTE;
            tx_en_d   = 1'b1;
            aux_d     = 8'd1;
            state_d   = (PREAMBLE_BYTES <= 1) ? ST_SFD : ST_PRE;
          end
        end
        ST_PRE: begin
          tx_data_d = PREAMBLE_BYTE;
          aux_d     = aux_q + 8'd1;
          if (aux_q >= PRE_LAST) state_d = ST_SFD;
        end
        ST_SFD: begin
          tx_data_d = SFD_BYTE;
          crc_init  = 1'b1;
          cnt_d     = 16'd0;
          state_d   = ST_DATA;
        end
        ST_DATA: begin
          aux_d = 8'd0;
          if (In_valid) begin
            tx_data_d = In_data;
            crc_en    = 1'b1;
            cnt_d     = cnt_inc;
            if (In_last) state_d = (cnt_inc < MIN_CNT) ? ST_PAD : ST_FCS;
          end else begin
            // underrun: drop the frame without FCS, flag it for one byte-time
            tx_data_d = 8'h00;
            tx_en_d   = 1'b0;
            tx_err_d  = 1'b1;
            state_d   = ST_IFG;
          end
        end
        ST_PAD: begin
          tx_data_d = 8'h00;
          crc_din   = 8'h00;
          crc_en    = 1'b1;
          cnt_d     = cnt_inc;
          aux_d     = 8'd0;
          if (cnt_inc >= MIN_CNT) state_d = ST_FCS;
        end
        ST_FCS: begin
          tx_data_d = ~bitrev8(fcs_src);
          aux_d     = aux_q + 8'd1;
          if (aux_q[1:0] == 2'd3) begin
            done_d  = 1'b1;
            aux_d   = 8'd0;
            state_d = ST_IFG;
          end
        end
        ST_IFG: begin
          tx_data_d = 8'h00;
          tx_en_d   = 1'b0;
          tx_err_d  = 1'b0;
          aux_d     = aux_q + 8'd1;
          if (aux_q >= IFG_LAST) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, counters and registered PHY-side outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      aux_q     <= 8'd0;
      tx_data_q <= 8'h00;
      tx_en_q   <= 1'b0;
      tx_err_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      aux_q     <= aux_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      tx_err_q  <= tx_err_d;
      done_q    <= done_d;
    end
  end

  assign In_ready   = (state_q == ST_DATA) && Tx_ready;
  assign Busy       = (state_q != ST_IDLE);
  assign Tx_data    = tx_data_q;
  assign Tx_en      = tx_en_q;
  assign Tx_err     = tx_err_q;
  assign Frame_done = done_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Self-checking bench for eth_tx_framer: dut0 has no padding, dut1 defaults.
module tb_eth_tx_framer;

  typedef logic [7:0] bq_t[$];

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] In_data = 8'h00;
  logic       In_valid = 1'b0;
  logic       In_last = 1'b0;
  logic       Tx_ready = 1'b1;
  logic       sel0 = 1'b0;
  logic       mii = 1'b0;
  logic       stb_q = 1'b0;

  logic       rdy0, rdy1, en0, en1, err0, err1, fd0, fd1, busy0, busy1;
  logic [7:0] td0, td1;
  logic       v0, v1;
  logic       rdy_m, tx_en_m, tx_err_m, fd_m, busy_m;
  logic [7:0] tx_data_m;

  int n_cmp = 0;
  int n_err = 0;

  bq_t        exp_q, cap_q;
  int         cap_lead, cap_err, cap_fd, cap_ifg, cap_hold_bad;
  logic [7:0] cap_fd_data;
  bit         cap_to, drv_to;

  assign v0 = In_valid & sel0;
  assign v1 = In_valid & ~sel0;
  assign rdy_m     = sel0 ? rdy0  : rdy1;
  assign tx_data_m = sel0 ? td0   : td1;
  assign tx_en_m   = sel0 ? en0   : en1;
  assign tx_err_m  = sel0 ? err0  : err1;
  assign fd_m      = sel0 ? fd0   : fd1;
  assign busy_m    = sel0 ? busy0 : busy1;

  eth_tx_framer #(.MIN_FRAME(0)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .In_data(In_data), .In_valid(v0), .In_last(In_last),
    .In_ready(rdy0), .Tx_ready(Tx_ready), .Tx_data(td0), .Tx_en(en0), .Tx_err(err0),
    .Frame_done(fd0), .Busy(busy0));

  eth_tx_framer dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .In_data(In_data), .In_valid(v1), .In_last(In_last),
    .In_ready(rdy1), .Tx_ready(Tx_ready), .Tx_data(td1), .Tx_en(en1), .Tx_err(err1),
    .Frame_done(fd1), .Busy(busy1));

  always #5 Clk = ~Clk;

  // byte-time strobe: every clock, or every other clock in MII mode
  initial forever begin
    @(posedge Clk); #1;
    Tx_ready = mii ? ~Tx_ready : 1'b1;
  end

  // remembers whether the last rising edge was a strobe
  always @(posedge Clk) stb_q <= Tx_ready;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // reference: reflected software CRC-32, returned as the on-wire FCS value
  function automatic logic [31:0] sw_fcs(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic mk(input int n, input logic [7:0] seed, output bq_t q);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(8'(seed + 8'(i * 7)));
  endtask

  task automatic build_exp(input bq_t pl, input int minf, input int stop_at);
    bq_t fr;
    logic [31:0] f;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < pl.size(); i++) begin
      if (i == stop_at) break;
      fr.push_back(pl[i]);
    end
    if (stop_at < 0) while (fr.size() < minf) fr.push_back(8'h00);
    foreach (fr[i]) exp_q.push_back(fr[i]);
    if (stop_at < 0) begin
      f = sw_fcs(fr);
      exp_q.push_back(f[7:0]);   exp_q.push_back(f[15:8]);
      exp_q.push_back(f[23:16]); exp_q.push_back(f[31:24]);
    end
  endtask

  // presents payload bytes; at index stop_at drops In_valid and returns
  task automatic send(input bq_t pl, input int stop_at);
    int  w;
    bit  fire;
    for (int i = 0; i < pl.size(); i++) begin
      if (i == stop_at) begin In_valid = 1'b0; In_last = 1'b0; return; end
      In_valid = 1'b1; In_data = pl[i]; In_last = (i == pl.size() - 1);
      w = 0; fire = 1'b0;
      while (!fire && w < 2000) begin
        @(negedge Clk); fire = In_valid && rdy_m;
        @(posedge Clk); #1; w++;
      end
      if (!fire) begin drv_to = 1'b1; In_valid = 1'b0; return; end
    end
    In_valid = 1'b0; In_last = 1'b0;
  endtask

  // records one frame's Tx_en bytes, then the gap until the framer is idle
  task automatic capture(input int max_cyc);
    int         phase;
    bit         done;
    logic [7:0] prev;
    cap_q.delete();
    cap_lead = 0; cap_err = 0; cap_fd = 0; cap_ifg = 0; cap_hold_bad = 0;
    cap_fd_data = 8'h00; phase = 0; done = 1'b0;
    @(posedge Clk);
    prev = tx_data_m;
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(negedge Clk);
      if (fd_m) begin cap_fd++; cap_fd_data = tx_data_m; end
      if (!stb_q) begin
        if (phase == 1 && tx_data_m !== prev) cap_hold_bad++;
      end else if (phase == 0) begin
        if (tx_en_m) begin phase = 1; cap_q.push_back(tx_data_m); end
        else cap_lead++;
      end else if (phase == 1 && tx_en_m) begin
        cap_q.push_back(tx_data_m);
      end else begin
        phase = 2;
        if (tx_err_m) cap_err++; else cap_ifg++;
        if (!busy_m) done = 1'b1;
      end
      prev = tx_data_m;
    end
    cap_to = !done;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; In_valid = 1'b0; sel0 = 1'b0;
    repeat (3) @(negedge Clk);
    n_cmp++; if (td1 !== 8'h00) begin n_err++; $display("FAIL rst_tx_data got %h required 00", td1); end
    n_cmp++; if (en1 !== 1'b0 || en0 !== 1'b0) begin n_err++; $display("FAIL rst_tx_en got %b/%b required 0", en1, en0); end
    n_cmp++; if (err1 !== 1'b0) begin n_err++; $display("FAIL rst_tx_err got %b required 0", err1); end
    n_cmp++; if (fd1 !== 1'b0) begin n_err++; $display("FAIL rst_frame_done got %b required 0", fd1); end
    n_cmp++; if (busy1 !== 1'b0 || busy0 !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b/%b required 0", busy1, busy0); end
    n_cmp++; if (rdy1 !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b required 0", rdy1); end
    @(posedge Clk); #1; Reset_n = 1'b1;
    repeat (2) @(posedge Clk); #1;
  endtask

  // "123456789" without padding: FCS must be the textbook check value
  task automatic run_check_frame(input string nm, input bit hold);
    bq_t pl;
    logic [7:0] e, o;
    int k;
    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'(8'h31 + i));
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (pl[i]) exp_q.push_back(pl[i]);
    exp_q.push_back(8'h26); exp_q.push_back(8'h39); exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
    drv_to = 1'b0;
    fork
      send(pl, -1);
      capture(4000);
    join
    n_cmp++; if (drv_to || cap_to) begin n_err++; $display("FAIL %s_timeout drv=%0b cap=%0b required 0", nm, drv_to, cap_to); end
    n_cmp++; if (cap_lead !== 0) begin n_err++; $display("FAIL %s_latency got %0d idle strobes before preamble required 0", nm, cap_lead); end
    n_cmp++; if (cap_q.size() != exp_q.size()) begin n_err++; $display("FAIL %s_len got %0d required %0d", nm, cap_q.size(), exp_q.size()); end
    k = 0;
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front(); o = cap_q.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL %s_byte%0d got %h required %h", nm, k, o, e); end
      k++;
    end
    n_cmp++; if (cap_fd !== 1 || cap_fd_data !== 8'hCB) begin n_err++; $display("FAIL %s_frame_done got %0d pulses with %h required 1 with CB", nm, cap_fd, cap_fd_data); end
    n_cmp++; if (cap_ifg !== 12 || cap_err !== 0) begin n_err++; $display("FAIL %s_ifg got %0d idle/%0d err required 12/0", nm, cap_ifg, cap_err); end
    if (hold) begin
      n_cmp++; if (cap_hold_bad !== 0) begin n_err++; $display("FAIL %s_hold got %0d changes between strobes required 0", nm, cap_hold_bad); end
    end
  endtask

  task automatic test_min0_frame();
    sel0 = 1'b1; mii = 1'b0;
    run_check_frame("t1", 1'b0);
  endtask

  task automatic test_mii_rate();
    sel0 = 1'b1; mii = 1'b1;
    repeat (2) @(posedge Clk); #1;
    run_check_frame("t3", 1'b1);
    mii = 1'b0;
    repeat (2) @(posedge Clk); #1;
  endtask

  task automatic test_pad();
    bq_t pl;
    logic [7:0] e, o;
    int k;
    sel0 = 1'b0; drv_to = 1'b0;
    mk(14, 8'hA0, pl);
    build_exp(pl, 60, -1);
    fork
      send(pl, -1);
      capture(4000);
    join
    n_cmp++; if (drv_to || cap_to) begin n_err++; $display("FAIL t2_timeout drv=%0b cap=%0b required 0", drv_to, cap_to); end
    n_cmp++; if (cap_q.size() != 72) begin n_err++; $display("FAIL t2_len got %0d required 72", cap_q.size()); end
    k = 0;
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front(); o = cap_q.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL t2_byte%0d got %h required %h", k, o, e); end
      k++;
    end
    n_cmp++; if (cap_fd !== 1) begin n_err++; $display("FAIL t2_frame_done got %0d pulses required 1", cap_fd); end
  endtask

  task automatic test_underrun();
    bq_t pl;
    logic [7:0] e, o;
    int k;
    sel0 = 1'b0; drv_to = 1'b0;
    mk(30, 8'h11, pl);
    build_exp(pl, 60, 20);
    fork
      send(pl, 20);
      capture(4000);
    join
    n_cmp++; if (cap_to) begin n_err++; $display("FAIL t4_timeout cap=%0b required 0", cap_to); end
    n_cmp++; if (cap_q.size() != exp_q.size()) begin n_err++; $display("FAIL t4_len got %0d required %0d", cap_q.size(), exp_q.size()); end
    k = 0;
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front(); o = cap_q.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL t4_byte%0d got %h required %h", k, o, e); end
      k++;
    end
    n_cmp++; if (cap_err !== 1) begin n_err++; $display("FAIL t4_tx_err got %0d strobes required 1", cap_err); end
    n_cmp++; if (cap_fd !== 0) begin n_err++; $display("FAIL t4_no_fcs got %0d frame_done required 0", cap_fd); end
    n_cmp++; if (cap_ifg !== 12) begin n_err++; $display("FAIL t4_ifg got %0d required 12", cap_ifg); end
    // the following frame must be clean
    mk(25, 8'h3C, pl);
    build_exp(pl, 60, -1);
    fork
      send(pl, -1);
      capture(4000);
    join
    n_cmp++; if (drv_to || cap_to) begin n_err++; $display("FAIL t4b_timeout drv=%0b cap=%0b required 0", drv_to, cap_to); end
    n_cmp++; if (cap_q.size() != exp_q.size()) begin n_err++; $display("FAIL t4b_len got %0d required %0d", cap_q.size(), exp_q.size()); end
    k = 0;
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front(); o = cap_q.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL t4b_byte%0d got %h required %h", k, o, e); end
      k++;
    end
  endtask

  task automatic test_back_to_back();
    bq_t p1, p2, q1;
    logic [7:0] e, o;
    int k, f1_fd, f1_ifg;
    bit f1_to;
    sel0 = 1'b0; drv_to = 1'b0;
    mk(60, 8'h05, p1);   // exactly MIN_FRAME: no pad
    mk(59, 8'h9A, p2);   // one short: a single pad byte
    fork
      begin send(p1, -1); send(p2, -1); end
      begin
        capture(6000);
        q1 = cap_q; f1_fd = cap_fd; f1_ifg = cap_ifg; f1_to = cap_to;
        capture(6000);
      end
    join
    n_cmp++; if (drv_to || f1_to || cap_to) begin n_err++; $display("FAIL t5_timeout drv=%0b cap=%0b/%0b required 0", drv_to, f1_to, cap_to); end
    n_cmp++; if (f1_ifg !== 12 || cap_lead !== 0) begin n_err++; $display("FAIL t5_gap got %0d idle + %0d extra strobes required 12 + 0", f1_ifg, cap_lead); end
    n_cmp++; if (f1_fd !== 1 || cap_fd !== 1) begin n_err++; $display("FAIL t5_frame_done got %0d/%0d required 1/1", f1_fd, cap_fd); end
    build_exp(p1, 60, -1);
    n_cmp++; if (q1.size() != 72) begin n_err++; $display("FAIL t5a_len got %0d required 72", q1.size()); end
    k = 0;
    while (exp_q.size() > 0 && q1.size() > 0) begin
      e = exp_q.pop_front(); o = q1.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL t5a_byte%0d got %h required %h", k, o, e); end
      k++;
    end
    build_exp(p2, 60, -1);
    n_cmp++; if (cap_q.size() != 72) begin n_err++; $display("FAIL t5b_len got %0d required 72", cap_q.size()); end
    k = 0;
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front(); o = cap_q.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL t5b_byte%0d got %h required %h", k, o, e); end
      k++;
    end
  endtask

  task automatic test_reset_mid();
    bq_t pl;
    logic [7:0] e, o;
    int k;
    sel0 = 1'b0; drv_to = 1'b0;
    mk(40, 8'h77, pl);
    send(pl, 30);
    n_cmp++; if (tx_en_m !== 1'b1 || busy_m !== 1'b1) begin n_err++; $display("FAIL t6_midframe got en=%b busy=%b required 1/1", tx_en_m, busy_m); end
    #2 Reset_n = 1'b0;
    #1;
    n_cmp++; if (td1 !== 8'h00 || en1 !== 1'b0 || err1 !== 1'b0) begin n_err++; $display("FAIL t6_async_out got data=%h en=%b err=%b required 00/0/0", td1, en1, err1); end
    n_cmp++; if (fd1 !== 1'b0 || busy1 !== 1'b0 || rdy1 !== 1'b0) begin n_err++; $display("FAIL t6_async_ctl got fd=%b busy=%b rdy=%b required 0/0/0", fd1, busy1, rdy1); end
    repeat (3) @(posedge Clk); #1;
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    mk(16, 8'hE1, pl);
    build_exp(pl, 60, -1);
    fork
      send(pl, -1);
      capture(4000);
    join
    n_cmp++; if (drv_to || cap_to) begin n_err++; $display("FAIL t6_timeout drv=%0b cap=%0b required 0", drv_to, cap_to); end
    n_cmp++; if (cap_q.size() != exp_q.size()) begin n_err++; $display("FAIL t6_len got %0d required %0d", cap_q.size(), exp_q.size()); end
    k = 0;
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front(); o = cap_q.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL t6_byte%0d got %h required %h", k, o, e); end
      k++;
    end
  endtask

  initial begin
    test_reset();
    test_min0_frame();
    test_pad();
    test_mii_rate();
    test_underrun();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
